// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button conditioner.
// State encoding and board key positions are shared by the channel, the top and their users.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      S_RELEASED    = 2'b00,
      S_PRESS_CHK   = 2'b01,
      S_PRESSED     = 2'b10,
      S_RELEASE_CHK = 2'b11
   } key_state_e;

   localparam int KEY_START = 0;
   localparam int KEY_CATCH = 1;
   localparam int KEY_PREV  = 2;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM with stability counter,
// and registered press pulse / release pulse / level outputs.
module key_debounce_ch
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_key_pulse,
   output logic o_key_release,
   output logic o_key_level
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync0_q, sync0_d;
   logic             sync1_q, sync1_d;
   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;
   logic             release_q, release_d;
   logic             level_q, level_d;
   logic             pressed;

   // Synchronizer resets to released so a key held through reset is seen as a fresh press.
   always_comb begin
      sync0_d = i_key_n;
      sync1_d = sync0_q;
   end

   assign pressed = ~sync1_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pulse_d   = 1'b0;
      release_d = 1'b0;
      level_d   = level_q;

      case (state_q)
         S_RELEASED: begin
            cnt_d = '0;
            if (pressed) begin
               state_d = S_PRESS_CHK;
            end
         end

         S_PRESS_CHK: begin
            if (!pressed) begin
               state_d = S_RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = S_PRESSED;
               cnt_d   = '0;
               pulse_d = 1'b1;
               level_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_PRESSED: begin
            cnt_d = '0;
            if (!pressed) begin
               state_d = S_RELEASE_CHK;
            end
         end

         // A short release glitch falls back to PRESSED silently; level stays high.
         S_RELEASE_CHK: begin
            if (pressed) begin
               state_d = S_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = S_RELEASED;
               cnt_d     = '0;
               release_d = 1'b1;
               level_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = S_RELEASED;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync0_q   <= 1'b1;
         sync1_q   <= 1'b1;
         state_q   <= S_RELEASED;
         cnt_q     <= '0;
         pulse_q   <= 1'b0;
         release_q <= 1'b0;
         level_q   <= 1'b0;
      end else begin
         sync0_q   <= sync0_d;
         sync1_q   <= sync1_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pulse_q   <= pulse_d;
         release_q <= release_d;
         level_q   <= level_d;
      end
   end

   assign o_key_pulse   = pulse_q;
   assign o_key_release = release_q;
   assign o_key_level   = level_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner for the game controller's start/catch/prev keys.
// Channels are fully independent; simultaneous events are passed through unprioritized.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int NUM_KEYS        = 3,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NUM_KEYS-1:0] i_key_n,
   output logic [NUM_KEYS-1:0] o_key_pulse,
   output logic [NUM_KEYS-1:0] o_key_release,
   output logic [NUM_KEYS-1:0] o_key_level
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .i_clk         (i_clk),
         .i_rst         (i_rst),
         .i_key_n       (i_key_n[g]),
         .o_key_pulse   (o_key_pulse[g]),
         .o_key_release (o_key_release[g]),
         .o_key_level   (o_key_level[g])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulse cycles are queued when keys are driven
// and matched against the DUT's pulses on the falling clock edge.
module tb_key_debounce;

   localparam int NK  = 3;
   localparam int DC  = 4;
   localparam int LAT = DC + 2;

   logic          clk;
   logic          rst;
   logic [NK-1:0] key_n;
   logic [NK-1:0] o_key_pulse;
   logic [NK-1:0] o_key_release;
   logic [NK-1:0] o_key_level;

   int cyc;
   int n_assert;
   int n_fail;
   int exp_press[NK][$];
   int exp_release[NK][$];
   int mon_e;

   key_debounce #(
      .NUM_KEYS(NK),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_key_n       (key_n),
      .o_key_pulse   (o_key_pulse),
      .o_key_release (o_key_release),
      .o_key_level   (o_key_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every observed pulse must match the oldest expected cycle for its key.
   always @(negedge clk) begin
      for (int k = 0; k < NK; k++) begin
         if (o_key_pulse[k] === 1'b1) begin
            n_assert++;
            if (exp_press[k].size() == 0) begin
               n_fail++;
               $display("FAIL press_pulse key%0d: pulse seen at cycle %0d, required none", k, cyc);
            end else begin
               mon_e = exp_press[k].pop_front();
               if (cyc !== mon_e) begin
                  n_fail++;
                  $display("FAIL press_pulse key%0d: pulse at cycle %0d, required cycle %0d", k, cyc, mon_e);
               end
            end
         end
         if (o_key_release[k] === 1'b1) begin
            n_assert++;
            if (exp_release[k].size() == 0) begin
               n_fail++;
               $display("FAIL release_pulse key%0d: pulse seen at cycle %0d, required none", k, cyc);
            end else begin
               mon_e = exp_release[k].pop_front();
               if (cyc !== mon_e) begin
                  n_fail++;
                  $display("FAIL release_pulse key%0d: pulse at cycle %0d, required cycle %0d", k, cyc, mon_e);
               end
            end
         end
      end
   end

   task automatic test_reset();
      #3;
      rst = 1'b1;
      #1;
      n_assert++;
      if ({o_key_pulse, o_key_release, o_key_level} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, required 0", {o_key_pulse, o_key_release, o_key_level});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         n_assert++;
         if ({o_key_pulse, o_key_release, o_key_level} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b at cycle %0d, required 0",
                     {o_key_pulse, o_key_release, o_key_level}, cyc);
         end
      end
   endtask

   task automatic test_clean_press();
      int e0;
      int r0;
      @(negedge clk);
      key_n[0] = 1'b0;
      e0 = cyc + 1;
      exp_press[0].push_back(e0 + LAT);
      repeat (30) begin
         @(negedge clk);
         n_assert++;
         if (o_key_level[0] !== (cyc >= e0 + LAT)) begin
            n_fail++;
            $display("FAIL clean_press_level: got %b at cycle %0d, required %b",
                     o_key_level[0], cyc, (cyc >= e0 + LAT));
         end
      end
      key_n[0] = 1'b1;
      r0 = cyc + 1;
      exp_release[0].push_back(r0 + LAT);
      repeat (12) begin
         @(negedge clk);
         n_assert++;
         if (o_key_level[0] !== (cyc < r0 + LAT)) begin
            n_fail++;
            $display("FAIL clean_release_level: got %b at cycle %0d, required %b",
                     o_key_level[0], cyc, (cyc < r0 + LAT));
         end
      end
   endtask

   task automatic test_bounce();
      int e0;
      int r0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         key_n[1] = 1'b0;
         repeat (2) begin
            @(negedge clk);
            n_assert++;
            if (o_key_level[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL bounce_level: got %b at cycle %0d, required 0", o_key_level[1], cyc);
            end
         end
         key_n[1] = 1'b1;
         repeat (2) begin
            @(negedge clk);
            n_assert++;
            if (o_key_level[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL bounce_level: got %b at cycle %0d, required 0", o_key_level[1], cyc);
            end
         end
      end
      key_n[1] = 1'b0;
      e0 = cyc + 1;
      exp_press[1].push_back(e0 + LAT);
      repeat (12) begin
         @(negedge clk);
         n_assert++;
         if (o_key_level[1] !== (cyc >= e0 + LAT)) begin
            n_fail++;
            $display("FAIL bounce_settle_level: got %b at cycle %0d, required %b",
                     o_key_level[1], cyc, (cyc >= e0 + LAT));
         end
      end
      key_n[1] = 1'b1;
      r0 = cyc + 1;
      exp_release[1].push_back(r0 + LAT);
      repeat (12) @(negedge clk);
   endtask

   task automatic test_release_glitch();
      int e0;
      int r0;
      @(negedge clk);
      key_n[2] = 1'b0;
      e0 = cyc + 1;
      exp_press[2].push_back(e0 + LAT);
      repeat (10) @(negedge clk);
      key_n[2] = 1'b1;
      repeat (2) @(negedge clk);
      key_n[2] = 1'b0;
      repeat (14) begin
         @(negedge clk);
         n_assert++;
         if (o_key_level[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_level: got %b at cycle %0d, required 1", o_key_level[2], cyc);
         end
      end
      key_n[2] = 1'b1;
      r0 = cyc + 1;
      exp_release[2].push_back(r0 + LAT);
      repeat (12) @(negedge clk);
   endtask

   task automatic test_simultaneous();
      int e0;
      int r0;
      @(negedge clk);
      key_n[0] = 1'b0;
      key_n[2] = 1'b0;
      e0 = cyc + 1;
      exp_press[0].push_back(e0 + LAT);
      exp_press[2].push_back(e0 + LAT);
      repeat (12) begin
         @(negedge clk);
         n_assert++;
         if ({o_key_pulse[2], o_key_pulse[0]} !== ((cyc == e0 + LAT) ? 2'b11 : 2'b00)) begin
            n_fail++;
            $display("FAIL simultaneous_pulse: got %b at cycle %0d, required %b",
                     {o_key_pulse[2], o_key_pulse[0]}, cyc, ((cyc == e0 + LAT) ? 2'b11 : 2'b00));
         end
      end
      key_n[0] = 1'b1;
      key_n[2] = 1'b1;
      r0 = cyc + 1;
      exp_release[0].push_back(r0 + LAT);
      exp_release[2].push_back(r0 + LAT);
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset_mid_count();
      int e0;
      int r0;
      @(negedge clk);
      key_n[1] = 1'b0;
      e0 = cyc + 1;
      exp_press[1].push_back(e0 + LAT);
      repeat (10) @(negedge clk);
      // Key 0's press is interrupted by reset and must not produce a pulse.
      key_n[0] = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_assert++;
      if ({o_key_pulse, o_key_release, o_key_level} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_count_clear: got %b, required 0",
                  {o_key_pulse, o_key_release, o_key_level});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      e0 = cyc + 1;
      exp_press[0].push_back(e0 + LAT);
      exp_press[1].push_back(e0 + LAT);
      repeat (12) begin
         @(negedge clk);
         n_assert++;
         if (o_key_level[1:0] !== ((cyc >= e0 + LAT) ? 2'b11 : 2'b00)) begin
            n_fail++;
            $display("FAIL reset_mid_count_level: got %b at cycle %0d, required %b",
                     o_key_level[1:0], cyc, ((cyc >= e0 + LAT) ? 2'b11 : 2'b00));
         end
      end
      key_n[0] = 1'b1;
      key_n[1] = 1'b1;
      r0 = cyc + 1;
      exp_release[0].push_back(r0 + LAT);
      exp_release[1].push_back(r0 + LAT);
      repeat (12) @(negedge clk);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b0;
      key_n    = '1;

      test_reset();
      test_clean_press();
      test_bounce();
      test_release_glitch();
      test_simultaneous();
      test_reset_mid_count();

      for (int k = 0; k < NK; k++) begin
         n_assert++;
         if (exp_press[k].size() != 0) begin
            n_fail++;
            $display("FAIL press_missing key%0d: %0d pulses outstanding, required 0", k, exp_press[k].size());
         end
         n_assert++;
         if (exp_release[k].size() != 0) begin
            n_fail++;
            $display("FAIL release_missing key%0d: %0d pulses outstanding, required 0", k, exp_release[k].size());
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
